uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
- Parametrised successor to the fixed 8N1 receiver inside uart_top.
- Configurable data width, parity and stop bits.
- 16x-style oversampling with 3-sample majority vote; parity, framing, break and overrun detection.
- Valid/ready output holding register; feeds the echo path or a FIFO in the next uart_top revision.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 8.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_serial  in  1  asynchronous serial line; idles high.
- m_data  out  DATA_BITS  received payload, LSB = first bit on the wire.
- m_valid  out  1  m_data and flags hold a frame.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- parity_err  out  1  parity mismatch for the held frame; qualified by m_valid.
- frame_err  out  1  a stop bit sampled low in the held frame; qualified by m_valid.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- break_det  out  1  one-cycle pulse: break condition detected.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (async, rst_n low): m_data 0, m_valid 0, all flags 0, busy 0, FSM IDLE, synchroniser stages 1.
- rx_serial passes through a 2-flop synchroniser; all logic uses the synchronised signal.
- Tick divisor DIV = round(CLK_FREQ / (BAUD_RATE * OVERSAMPLE)); with defaults DIV = 326.
- Tick counter free-runs, but clears on start-edge detection so sampling is phase-aligned to the frame.
- Bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START on a high-to-low transition of the synchronised line.
- START: at mid-bit, majority 1 means false start -> IDLE (no flags); majority 0 -> DATA.
- DATA: shift in DATA_BITS bits LSB first; then -> PARITY if PARITY != 0, else -> STOP.
- PARITY: odd mode expects XOR(data, parity bit) = 1; even mode expects 0.
- STOP: sample STOP_BITS stop bits; any low sample sets the frame_err candidate.
- FSM returns to IDLE immediately after the mid-sample of the last stop bit, so a new start edge can be caught in the remainder of that stop bit.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - Fires break_det one cycle after that stop mid-sample.
  - No frame is delivered.
  - FSM -> BREAK_WAIT, which stays until the line has been high for one full bit time, then -> IDLE.
- Delivery: one cycle after the last stop mid-sample, the frame loads into the holding register if it is empty or being accepted that same cycle.
  - Load sets m_valid = 1 and latches parity_err and frame_err with the data.
  - Errored frames are still delivered, with their flags set.
- m_valid stays high and m_data/flags stay stable until m_valid && m_ready.
- Frame completes while m_valid=1 && m_ready=0: new frame is discarded, old frame kept, overrun pulses one cycle.
- Accept and load in the same cycle: load wins, m_valid stays 1, no overrun.
- busy = (state != IDLE).
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is lost.
- After rst_n deasserts with the line held low, no start is detected until a falling edge is seen.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - rx FSM state enum;
  - divisor function calc_div(clk, baud, os).
- Sub-module uart_baud_tick: divisor counter with synchronous clear input and a one-cycle tick output.
  - It is to be reused by the matching configurable transmitter.

Test Plan:
- Defaults (8N1, 9600 baud, 50 MHz), bit period 104167 ns; send 0x41, 0x42, 0x43 with m_ready=1 -> three single-cycle m_valid, m_data 0x41/0x42/0x43, all flags 0.
- DATA_BITS=7, PARITY=2, STOP_BITS=2; send 0x35 with parity 0 -> m_data 0x35, parity_err 0; resend with parity 1 -> parity_err 1 alongside m_data 0x35.
- 8N1, send 0xA5 with stop bit forced 0 -> m_data 0xA5, frame_err 1; next frame 0x5A sent clean -> frame_err 0.
- Hold m_ready=0; send 0x11 then 0x22 -> m_data stays 0x11, overrun pulses once at 0x22 completion; raise m_ready -> 0x11 accepted, m_valid drops.
- Hold line low for 2 frame times -> break_det pulses once, m_valid stays 0; release; send 0x7E -> delivered normally.
- Glitch low for 3 us, then assert rst_n low for 5 cycles in the middle of a 0xFF frame -> no m_valid for either, busy returns to 0; next 0x00 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared UART constants, receiver FSM encoding and the baud divisor helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

   // Parity modes, as used by the PARITY parameter of the rx/tx blocks
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Receiver FSM encoding
   typedef enum logic [2:0] {
      RX_IDLE       = 3'd0,
      RX_START      = 3'd1,
      RX_DATA       = 3'd2,
      RX_PARITY     = 3'd3,
      RX_STOP       = 3'd4,
      RX_BREAK_WAIT = 3'd5
   } rx_state_e;

   // Rounded clock divisor giving one oversampling tick; never returns 0
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned per_s;
      int unsigned div;
      per_s = baud * os;
      div   = (clk_hz + per_s / 2) / per_s;
      if (div == 0) div = 1;
      return div;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: divide core clock down to a one-cycle oversampling tick; shared by rx and tx.
// Latency: first tick DIV cycles after reset or after a clear.
// Backpressure: none; free-running, clr_i restarts the phase and suppresses the tick that cycle.
module uart_baud_tick #(
   parameter int unsigned DIV = 326
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear has priority, otherwise wrap at DIV-1
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Divisor counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Purpose: configurable UART receiver (5..9 data bits, none/odd/even parity, 1..2 stop) with break/overrun detect.
// Latency: frame visible on m_valid one cycle after the mid-sample of its last stop bit.
// Backpressure: one-entry holding register; a frame completing while it is full is dropped and overrun pulses.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int          DATA_BITS  = 8,
   parameter int          PARITY     = 0,
   parameter int          STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 break_det,
   output logic                 busy
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BC_W = 4;

   // Three samples straddle the bit centre; the last one is the decision point
   localparam logic [OS_W-1:0] S_LO     = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] S_MID    = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0] S_HI     = OS_W'(OVERSAMPLE / 2 + 1);
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);
   localparam logic            STOP_LAST = (STOP_BITS == 2);

   // Synchroniser and edge detector
   logic       sync1_q, sync2_q, prev_q;
   logic [1:0] settle_q;
   logic       rx_s;
   logic       fall;
   logic       start_det;

   // Sampling
   logic            tick;
   logic [OS_W-1:0] os_cnt_q;
   logic [1:0]      samp_q;
   logic            mid;
   logic            bit_val;

   // FSM and frame assembly
   rx_state_e            state_q, state_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_acc_q, par_acc_d;
   logic                 zero_q, zero_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [OS_W-1:0]      hi_cnt_q, hi_cnt_d;
   logic                 frame_done;
   logic                 brk_hit;

   // Output holding register
   logic [DATA_BITS-1:0] m_data_q;
   logic                 m_valid_q;
   logic                 perr_out_q;
   logic                 ferr_out_q;
   logic                 overrun_q;
   logic                 break_q;

   // Two-flop synchroniser plus a previous-value flop; settle_q blocks a fake edge
   // right after reset when the line is already low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         settle_q <= 2'd0;
      end else begin
         sync1_q <= rx_serial;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (settle_q != 2'd3) begin
            settle_q <= settle_q + 1'b1;
         end
      end
   end

   assign rx_s      = sync2_q;
   assign fall      = (settle_q == 2'd3) && prev_q && !sync2_q;
   assign start_det = (state_q == RX_IDLE) && fall;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_det),
      .tick_o (tick)
   );

   // Tick position within the current bit, phase-aligned to the start edge,
   // and capture of the first two of the three centre samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt_q <= '0;
         samp_q   <= 2'b11;
      end else begin
         if (start_det) begin
            os_cnt_q <= '0;
         end else if (tick) begin
            os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
            if (os_cnt_q == S_LO)  samp_q[0] <= rx_s;
            if (os_cnt_q == S_MID) samp_q[1] <= rx_s;
         end
      end
   end

   assign mid     = tick && (os_cnt_q == S_HI);
   assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

   // Frame FSM: every decision is taken at the mid-sample of a bit
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_acc_d  = par_acc_q;
      zero_d     = zero_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      stop_cnt_d = stop_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      frame_done = 1'b0;
      brk_hit    = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (start_det) begin
               state_d    = RX_START;
               bit_cnt_d  = '0;
               par_acc_d  = 1'b0;
               zero_d     = 1'b1;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
               stop_cnt_d = 1'b0;
            end
         end
         RX_START: begin
            if (mid) begin
               state_d = bit_val ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (mid) begin
               shreg_d   = {bit_val, shreg_q[DATA_BITS-1:1]};
               par_acc_d = par_acc_q ^ bit_val;
               if (bit_val) zero_d = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (mid) begin
               if (bit_val) zero_d = 1'b0;
               perr_d  = (PARITY == PAR_ODD) ? ~(par_acc_q ^ bit_val) : (par_acc_q ^ bit_val);
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (mid) begin
               if (!stop_cnt_q && zero_q && !bit_val) begin
                  // All-zero frame with a low first stop bit: a break, not a character
                  brk_hit  = 1'b1;
                  hi_cnt_d = '0;
                  state_d  = RX_BREAK_WAIT;
               end else begin
                  if (!bit_val) ferr_d = 1'b1;
                  if (stop_cnt_q == STOP_LAST) begin
                     frame_done = 1'b1;
                     state_d    = RX_IDLE;
                  end else begin
                     stop_cnt_d = 1'b1;
                  end
               end
            end
         end
         RX_BREAK_WAIT: begin
            // Leave only after one full bit time of continuous idle-high line
            if (!rx_s) begin
               hi_cnt_d = '0;
            end else if (tick) begin
               if (hi_cnt_q == OS_LAST) begin
                  state_d = RX_IDLE;
               end else begin
                  hi_cnt_d = hi_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // FSM and frame assembly registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_acc_q  <= 1'b0;
         zero_q     <= 1'b1;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop_cnt_q <= 1'b0;
         hi_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_acc_q  <= par_acc_d;
         zero_q     <= zero_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         stop_cnt_q <= stop_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
      end
   end

   // Holding register: load on completion if empty or draining this cycle,
   // otherwise drop the new frame and flag overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         overrun_q  <= 1'b0;
         break_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         break_q   <= brk_hit;
         if (frame_done && (!m_valid_q || m_ready)) begin
            m_valid_q  <= 1'b1;
            m_data_q   <= shreg_q;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_d;
         end else begin
            if (frame_done) overrun_q <= 1'b1;
            if (m_valid_q && m_ready) m_valid_q <= 1'b0;
         end
      end
   end

   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_out_q;
   assign overrun    = overrun_q;
   assign break_det  = break_q;
   assign busy       = (state_q != RX_IDLE);

endmodule
